// File: rtl/prog_launcher_pkg.sv
// Shared types, program codes and the per-program memory layout for the job launcher.
package launcher_pkg;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PROG_W = 2;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [2:0] {IDLE, WRITE, START, WAIT, READ, RESP} state_t;

  localparam logic [PROG_W-1:0] PROG_RECIP = 2'd1;
  localparam logic [PROG_W-1:0] PROG_DIV   = 2'd2;
  localparam logic [PROG_W-1:0] PROG_SQRT  = 2'd3;

  localparam logic [ADDR_W-1:0] RECIP_WR_BASE = 8'd8;
  localparam logic [ADDR_W-1:0] RECIP_RD_BASE = 8'd10;
  localparam logic [ADDR_W-1:0] DIV_WR_BASE   = 8'd0;
  localparam logic [ADDR_W-1:0] DIV_RD_BASE   = 8'd4;
  localparam logic [ADDR_W-1:0] SQRT_WR_BASE  = 8'd12;
  localparam logic [ADDR_W-1:0] SQRT_RD_BASE  = 8'd14;

  localparam logic [IDX_W-1:0] RECIP_WR_CNT = 2'd2;
  localparam logic [IDX_W-1:0] RECIP_RD_CNT = 2'd2;
  localparam logic [IDX_W-1:0] DIV_WR_CNT   = 2'd3;
  localparam logic [IDX_W-1:0] DIV_RD_CNT   = 2'd3;
  localparam logic [IDX_W-1:0] SQRT_WR_CNT  = 2'd2;
  localparam logic [IDX_W-1:0] SQRT_RD_CNT  = 2'd1;

  typedef struct packed {
    logic [ADDR_W-1:0] wr_base;
    logic [IDX_W-1:0]  wr_cnt;
    logic [ADDR_W-1:0] rd_base;
    logic [IDX_W-1:0]  rd_cnt;
    logic              legal;
  } prog_info_t;

  // Operand byte idx of a cnt-byte operand, most significant byte first.
  function automatic logic [BYTE_W-1:0] pick_byte(input logic [DATA_W-1:0] data,
                                                  input logic [IDX_W-1:0]  cnt,
                                                  input logic [IDX_W-1:0]  idx);
    logic [IDX_W-1:0] pos;
    pos = cnt - idx - 2'd1;
    case (pos)
      2'd0:    return data[7:0];
      2'd1:    return data[15:8];
      default: return data[23:16];
    endcase
  endfunction

endpackage

// File: rtl/prog_launcher_if.sv
// Job request / response handshake between a host and the launcher.
interface prog_launcher_if;
  import launcher_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [PROG_W-1:0] req_prog;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_prog, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_prog, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/prog_launcher_map.sv
// Program code to data-memory layout lookup; code 0 reports illegal.
module prog_map
  import launcher_pkg::*;
(
  input  logic [PROG_W-1:0] prog,
  output prog_info_t        info
);

  always_comb begin
    info = '0;
    case (prog)
      PROG_RECIP: info = '{wr_base: RECIP_WR_BASE, wr_cnt: RECIP_WR_CNT,
                           rd_base: RECIP_RD_BASE, rd_cnt: RECIP_RD_CNT, legal: 1'b1};
      PROG_DIV:   info = '{wr_base: DIV_WR_BASE, wr_cnt: DIV_WR_CNT,
                           rd_base: DIV_RD_BASE, rd_cnt: DIV_RD_CNT, legal: 1'b1};
      PROG_SQRT:  info = '{wr_base: SQRT_WR_BASE, wr_cnt: SQRT_WR_CNT,
                           rd_base: SQRT_RD_BASE, rd_cnt: SQRT_RD_CNT, legal: 1'b1};
      default:    info = '0;
    endcase
  end

endmodule

// File: rtl/prog_launcher.sv
// Job launcher: writes operands to data memory, pulses start, waits for halt,
// reads the result bytes back and returns them on the response handshake.
module prog_launcher
  import launcher_pkg::*;
#(
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned HOLDOFF      = 2,
  parameter int unsigned TIMEOUT      = 4096
) (
  input  logic              CLK,
  input  logic              reset,
  prog_launcher_if.slave    host,
  output logic              start,
  input  logic              halt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BYTE_W-1:0] mem_wdata,
  input  logic [BYTE_W-1:0] mem_rdata
);

  localparam int unsigned SH_MAX  = (START_CYCLES > HOLDOFF) ? START_CYCLES : HOLDOFF;
  localparam int unsigned CNT_MAX = (TIMEOUT > SH_MAX) ? TIMEOUT : SH_MAX;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_t              state;
  logic [PROG_W-1:0]   prog_q;
  logic [DATA_W-1:0]   data_q;
  logic [IDX_W-1:0]    idx;
  logic [CNT_W-1:0]    cnt;
  logic                armed;
  logic [15:0]         result;
  logic [PROG_W-1:0]   map_prog;
  prog_info_t          info;

  // In IDLE the layout must come from the request itself so the first write issues on accept.
  assign map_prog = (state == IDLE) ? host.req_prog : prog_q;

  prog_map u_map (
    .prog (map_prog),
    .info (info)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state          <= IDLE;
      host.req_ready <= 1'b1;
      host.rsp_valid <= 1'b0;
      host.rsp_data  <= '0;
      host.rsp_err   <= 1'b0;
      start          <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      prog_q         <= '0;
      data_q         <= '0;
      idx            <= '0;
      cnt            <= '0;
      armed          <= 1'b0;
      result         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (host.req_valid && host.req_ready) begin
            prog_q         <= host.req_prog;
            data_q         <= host.req_data;
            result         <= '0;
            host.req_ready <= 1'b0;
            if (info.legal) begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_addr  <= info.wr_base;
              mem_wdata <= pick_byte(host.req_data, info.wr_cnt, 2'd0);
              idx       <= 2'd1;
            end else begin
              state         <= RESP;
              host.rsp_valid <= 1'b1;
              host.rsp_err   <= 1'b1;
              host.rsp_data  <= '0;
            end
          end
        end

        WRITE: begin
          if (idx == info.wr_cnt) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            start     <= 1'b1;
            cnt       <= CNT_W'(1);
            state     <= START;
          end else begin
            mem_addr  <= info.wr_base + ADDR_W'(idx);
            mem_wdata <= pick_byte(data_q, info.wr_cnt, idx);
            idx       <= idx + 2'd1;
          end
        end

        START: begin
          if (cnt == CNT_W'(START_CYCLES)) begin
            start <= 1'b0;
            cnt   <= '0;
            armed <= (HOLDOFF == 0);
            state <= WAIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Holdoff first (halt ignored, may be stale from the previous job), then timed wait.
        WAIT: begin
          if (!armed) begin
            if (cnt == CNT_W'(HOLDOFF - 1)) begin
              armed <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else if (halt) begin
            state    <= READ;
            mem_addr <= info.rd_base;
            idx      <= 2'd1;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state          <= RESP;
            host.rsp_valid <= 1'b1;
            host.rsp_err   <= 1'b1;
            host.rsp_data  <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        READ: begin
          result <= {result[7:0], mem_rdata};
          if (idx == info.rd_cnt) begin
            state          <= RESP;
            mem_addr       <= '0;
            host.rsp_valid <= 1'b1;
            host.rsp_err   <= 1'b0;
            host.rsp_data  <= {result, mem_rdata};
          end else begin
            mem_addr <= info.rd_base + ADDR_W'(idx);
            idx      <= idx + 2'd1;
          end
        end

        RESP: begin
          if (host.rsp_ready) begin
            host.rsp_valid <= 1'b0;
            host.rsp_err   <= 1'b0;
            host.rsp_data  <= '0;
            host.req_ready <= 1'b1;
            state          <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_launcher.sv
// Directed bench for prog_launcher with a 256x8 data memory and a TopLevel halt stub.
module tb_prog_launcher;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  prog_launcher_if bus ();

  logic       start, halt, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  prog_launcher #(.START_CYCLES(2), .HOLDOFF(2), .TIMEOUT(16)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .host      (bus.slave),
    .start     (start),
    .halt      (halt),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Data memory with a preload port used only while the launcher is idle
  logic [7:0] mem [0:255];
  logic       pl_en;
  logic [7:0] pl_addr, pl_data;
  always @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (pl_en) mem[pl_addr] <= pl_data;
  end
  assign mem_rdata = mem[mem_addr];

  // Halt stub: 0 = halt K cycles after start falls, 1 = never, 2 = only during holdoff, 3 = always
  int halt_mode;
  int halt_k;
  int since = 1000;
  always @(posedge CLK) begin
    if (start) since <= 0;
    else if (since < 1000) since <= since + 1;
  end
  always_comb begin
    case (halt_mode)
      0:       halt = !start && (since >= halt_k);
      1:       halt = 1'b0;
      2:       halt = !start && (since < 2);
      default: halt = 1'b1;
    endcase
  end

  logic [15:0] wr_log [$];
  int          start_hi = 0;
  always @(posedge CLK) begin
    if (mem_we) wr_log.push_back({mem_addr, mem_wdata});
    if (start) start_hi <= start_hi + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] v);
    @(negedge CLK);
    pl_addr = a; pl_data = v; pl_en = 1'b1;
    @(negedge CLK);
    pl_en = 1'b0;
  endtask

  // Presents one request; returns at the negedge right after the accepting edge.
  task automatic send(input logic [1:0] prog, input logic [23:0] data);
    @(negedge CLK);
    bus.req_prog = prog; bus.req_data = data; bus.req_valid = 1'b1;
    chk("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    bus.req_valid = 1'b0;
  endtask

  task automatic run_job(input logic [1:0] prog, input logic [23:0] data,
                         output int k, output logic [23:0] d, output logic e);
    send(prog, data);
    k = 0;
    while (!bus.rsp_valid && k < 200) begin
      @(negedge CLK);
      k++;
    end
    chk("rsp_seen", 32'(bus.rsp_valid), 32'd1);
    d = bus.rsp_data;
    e = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.rsp_ready = 1'b0;
    chk("rsp_dropped", 32'(bus.rsp_valid), 32'd0);
    chk("ready_after_rsp", 32'(bus.req_ready), 32'd1);
  endtask

  logic       s_we [0:9], s_st [0:9], s_rv [0:9], s_rr [0:9];
  logic [7:0] s_a  [0:9], s_d  [0:9];
  int          base, s0, k, seen;
  logic [23:0] d;
  logic        e;

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_prog = '0; bus.req_data = '0; bus.rsp_ready = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    halt_mode = 3; halt_k = 10;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
    chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
    chk("rst_start",     32'(start),         32'd0);
    chk("rst_mem_we",    32'(mem_we),        32'd0);
    chk("rst_mem_addr",  32'(mem_addr),      32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata),     32'd0);
    reset = 1'b0;

    // p1 with halt already high: exact cycle timeline, then back-pressure
    preload(8'd10, 8'hAA);
    preload(8'd11, 8'hAB);
    base = wr_log.size(); s0 = start_hi;
    send(2'd1, 24'h000003);
    for (int i = 0; i < 10; i++) begin
      s_we[i] = mem_we; s_a[i] = mem_addr; s_d[i] = mem_wdata;
      s_st[i] = start; s_rv[i] = bus.rsp_valid; s_rr[i] = bus.req_ready;
      @(negedge CLK);
    end
    chk("p1_we_c0",   32'(s_we[0]), 32'd1);
    chk("p1_addr_c0", 32'(s_a[0]),  32'd8);
    chk("p1_wd_c0",   32'(s_d[0]),  32'h00);
    chk("p1_we_c1",   32'(s_we[1]), 32'd1);
    chk("p1_addr_c1", 32'(s_a[1]),  32'd9);
    chk("p1_wd_c1",   32'(s_d[1]),  32'h03);
    chk("p1_we_c2",   32'(s_we[2]), 32'd0);
    chk("p1_start_c1", 32'(s_st[1]), 32'd0);
    chk("p1_start_c2", 32'(s_st[2]), 32'd1);
    chk("p1_start_c3", 32'(s_st[3]), 32'd1);
    chk("p1_start_c4", 32'(s_st[4]), 32'd0);
    chk("p1_rsp_valid_c8", 32'(s_rv[8]), 32'd0);
    chk("p1_rsp_valid_c9", 32'(s_rv[9]), 32'd1);
    for (int i = 0; i < 10; i++) chk("p1_req_ready_busy", 32'(s_rr[i]), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_data",  32'(bus.rsp_data),  32'h00AAAB);
      chk("bp_rsp_err",   32'(bus.rsp_err),   32'd0);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge CLK);
    end
    bus.rsp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.rsp_ready = 1'b0;
    chk("p1_rsp_done",    32'(bus.rsp_valid), 32'd0);
    chk("p1_ready_again", 32'(bus.req_ready), 32'd1);
    chk("p1_wr_count",    32'(wr_log.size() - base), 32'd2);
    chk("p1_start_len",   32'(start_hi - s0), 32'd2);

    // p2 divide, halt K=10 cycles after start falls
    preload(8'd4, 8'h00);
    preload(8'd5, 8'h55);
    preload(8'd6, 8'h55);
    halt_mode = 0;
    base = wr_log.size();
    run_job(2'd2, 24'h000103, k, d, e);
    chk("p2_data", 32'(d), 32'h005555);
    chk("p2_err",  32'(e), 32'd0);
    chk("p2_wr_count", 32'(wr_log.size() - base), 32'd3);
    chk("p2_wr0", 32'(wr_log[base]),     32'h0000);
    chk("p2_wr1", 32'(wr_log[base + 1]), 32'h0101);
    chk("p2_wr2", 32'(wr_log[base + 2]), 32'h0203);

    // p3 sqrt, single result byte zero-extended
    preload(8'd14, 8'hFF);
    base = wr_log.size();
    run_job(2'd3, 24'h00FFFF, k, d, e);
    chk("p3_data", 32'(d), 32'h0000FF);
    chk("p3_err",  32'(e), 32'd0);
    chk("p3_wr_count", 32'(wr_log.size() - base), 32'd2);
    chk("p3_wr0", 32'(wr_log[base]),     32'h0CFF);
    chk("p3_wr1", 32'(wr_log[base + 1]), 32'h0DFF);

    // Illegal program: immediate error, no memory or start activity
    base = wr_log.size(); s0 = start_hi;
    run_job(2'd0, 24'h123456, k, d, e);
    chk("ill_latency", 32'(k <= 1), 32'd1);
    chk("ill_err",  32'(e), 32'd1);
    chk("ill_data", 32'(d), 32'd0);
    chk("ill_no_write", 32'(wr_log.size() - base), 32'd0);
    chk("ill_no_start", 32'(start_hi - s0), 32'd0);

    // Timeout: start falls after edge 4, error response 2+16 edges later
    halt_mode = 1;
    run_job(2'd1, 24'h000003, k, d, e);
    chk("to_latency", 32'(k), 32'd22);
    chk("to_err",  32'(e), 32'd1);
    chk("to_data", 32'(d), 32'd0);

    // Halt high only during holdoff must not trigger a read
    halt_mode = 2;
    run_job(2'd1, 24'h000003, k, d, e);
    chk("hold_latency", 32'(k), 32'd22);
    chk("hold_err", 32'(e), 32'd1);

    // Reset while start is high
    halt_mode = 1;
    send(2'd1, 24'h000003);
    repeat (2) @(negedge CLK);
    chk("rst_start_pre", 32'(start), 32'd1);
    reset = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    chk("rst_start_drop", 32'(start), 32'd0);
    chk("rst_start_ready", 32'(bus.req_ready), 32'd1);

    // Reset during WAIT: no partial response afterwards
    send(2'd1, 24'h000003);
    repeat (5) @(negedge CLK);
    chk("wait_start_low", 32'(start), 32'd0);
    reset = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    chk("rstw_start",     32'(start),         32'd0);
    chk("rstw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstw_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rstw_mem_we",    32'(mem_we),        32'd0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (bus.rsp_valid || start || mem_we) seen++;
    end
    chk("rstw_quiet", 32'(seen), 32'd0);

    // Normal job after abort
    halt_mode = 3;
    preload(8'd14, 8'h3C);
    base = wr_log.size();
    run_job(2'd3, 24'h000010, k, d, e);
    chk("post_data", 32'(d), 32'h00003C);
    chk("post_wr0", 32'(wr_log[base]),     32'h0C00);
    chk("post_wr1", 32'(wr_log[base + 1]), 32'h0D10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
